// File: rtl/winograd_post_transform_2d_stream.sv
// Streaming 2D Winograd output transform Y = A^T * M * A, one tile at a time.
// Accepts the element-wise-product tile one row per beat, row-transforms each
// row into a buffer, then emits the spatial output tile one row per beat.
// Runtime modes: F(4,3) (6x6 in, 4x4 out) and F(2,3) (4x4 in, 2x2 out).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mode            0 = F(4,3), 1 = F(2,3); latched with row 0 of a tile
//   in_valid/ready  input row handshake; in_data = 6 signed DATA_W elements
//   out_valid/ready output row handshake; out_data = 4 signed OUT_W elements
//   out_last        final output row of a tile
//   out_sat         some element of this row saturated (or wrapped)
module winograd_post_transform_2d_stream #(
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 64,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*OUT_W-1:0]  out_data,
  output logic                out_last,
  output logic                out_sat
);

  localparam int RW = DATA_W + 5;   // exact row-pass width
  localparam int CW = DATA_W + 10;  // exact column-pass width

  typedef logic [CW-1:0] cw_t;
  typedef cw_t [5:0]     v6_t;
  typedef cw_t [3:0]     v4_t;
  typedef enum logic {LOAD, EMIT} state_t;

  // One 1D A^T pass; both passes share it. Shifts/adds only, modular at CW
  // bits, which is exact for both passes.
  function automatic v4_t xform(input v6_t a, input logic m);
    v4_t y;
    y = '0;
    if (m) begin
      y[0] = a[0] + a[1] + a[2];
      y[1] = a[1] - a[2] - a[3];
    end else begin
      y[0] = a[0] + a[1] + a[2] + a[3] + a[4];
      y[1] = a[1] - a[2] + (a[3] << 1) - (a[4] << 1);
      y[2] = a[1] + a[2] + (a[3] << 2) + (a[4] << 2);
      y[3] = a[1] - a[2] + (a[3] << 3) - (a[4] << 3) + a[5];
    end
    return y;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            rcnt;
  logic [1:0]            kcnt;
  logic                  mode_q;
  logic [3:0][RW-1:0]    tbuf [6];

  logic                  cur_mode;
  v6_t                   rin;
  v4_t                   rowt;
  logic [3:0][RW-1:0]    rowt_n;
  logic [1:0]            col_k;
  logic [3:0][OUT_W-1:0] onext;
  logic [3:0]            snext;
  logic                  acc, hs, last_in, last_out, col_last;

  // Row 0 uses the live mode input so the whole tile follows the mode
  // sampled at its first acceptance.
  assign cur_mode = (state_q == LOAD && rcnt == 3'd0) ? mode : mode_q;
  assign in_ready = (state_q == LOAD) & ~rst;
  assign acc      = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  assign last_in  = rcnt == (cur_mode ? 3'd3 : 3'd5);
  assign last_out = kcnt == (mode_q ? 2'd1 : 2'd3);
  // Output row 0 is produced on the edge that accepts the last input row,
  // so it is computed with that row bypassed around the buffer.
  assign col_k    = (state_q == LOAD) ? 2'd0 : kcnt + 2'd1;
  assign col_last = col_k == (cur_mode ? 2'd1 : 2'd3);

  for (genvar i = 0; i < 6; i++) begin : g_rin
    assign rin[i] = CW'($signed(in_data[i*DATA_W +: DATA_W]));
  end

  assign rowt = xform(rin, cur_mode);

  for (genvar j = 0; j < 4; j++) begin : g_col
    v6_t  cin;
    v4_t  cout;
    cw_t  v;
    logic hi_unused;

    assign rowt_n[j]  = rowt[j][RW-1:0];
    assign hi_unused  = ^rowt[j][CW-1:RW];

    for (genvar i = 0; i < 6; i++) begin : g_cin
      assign cin[i] = CW'($signed((state_q == LOAD && rcnt == 3'(i)) ?
                                  rowt_n[j] : tbuf[i][j]));
    end

    assign cout = xform(cin, cur_mode);
    assign v    = cout[col_k];

    if (OUT_W >= CW) begin : g_ext
      assign onext[j] = OUT_W'($signed(v));
      assign snext[j] = 1'b0;
    end else begin : g_sat
      logic fits;
      assign fits     = (&v[CW-1:OUT_W-1]) | ~(|v[CW-1:OUT_W-1]);
      assign snext[j] = ~fits;
      assign onext[j] = (fits || SATURATE == 0) ? v[OUT_W-1:0] :
                        (v[CW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (acc && last_in) state_d = EMIT;
      EMIT:    if (hs && last_out) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt      <= '0;
      kcnt      <= '0;
      mode_q    <= 1'b0;
      tbuf      <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      if (acc) begin
        tbuf[rcnt] <= rowt_n;
        if (rcnt == 3'd0) mode_q <= mode;
        rcnt <= last_in ? 3'd0 : rcnt + 3'd1;
        if (last_in) begin
          kcnt      <= '0;
          out_valid <= 1'b1;
          out_data  <= onext;
          out_last  <= col_last;
          out_sat   <= |snext;
        end
      end
      if (hs) begin
        if (last_out) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_sat   <= 1'b0;
        end else begin
          kcnt     <= kcnt + 2'd1;
          out_data <= onext;
          out_last <= col_last;
          out_sat  <= |snext;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_post_transform_2d_stream.sv
// Directed bench for winograd_post_transform_2d_stream: a table of tiles with
// hand-computed output tiles, plus sequences for mode toggling, back-to-back
// tiles, backpressure, narrow-output saturation/wrap and mid-tile reset.
module tb_winograd_post_transform_2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mode, in_valid, out_ready;
  logic [191:0] in_d32;
  logic [95:0]  in_d16;

  logic         in_ready, out_valid, out_last, out_sat;
  logic [255:0] out_data;
  logic         in_ready_s, out_valid_s, out_last_s, out_sat_s;
  logic [79:0]  out_data_s;
  logic         in_ready_w, out_valid_w, out_last_w, out_sat_w;
  logic [79:0]  out_data_w;

  winograd_post_transform_2d_stream #(.DATA_W(32), .OUT_W(64), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_d32), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_sat(out_sat));

  winograd_post_transform_2d_stream #(.DATA_W(16), .OUT_W(20), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_d16), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_last(out_last_s), .out_sat(out_sat_s));

  winograd_post_transform_2d_stream #(.DATA_W(16), .OUT_W(20), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_d16), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_last(out_last_w), .out_sat(out_sat_w));

  typedef struct packed {
    logic               mode;
    logic signed [31:0] fill;
    logic [2:0]         ir, ic;
    logic signed [31:0] iv;
    logic [15:0][63:0]  exp;   // exp[k*4+j] = out[k][j]
  } vec_t;

  int nvec = 0, nmis = 0;
  int tile [6][6];
  logic signed [19:0] gs [4][4], gw [4][4];
  logic sats [4], satw [4];
  vec_t tbl [6];

  function automatic logic [3:0][63:0] rw(input longint a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0][63:0] mk(input logic [3:0][63:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic vec_t mkv(input logic m, input int fill, input int ir, input int ic,
                               input int iv, input logic [15:0][63:0] e);
    vec_t v;
    v.mode = m; v.fill = fill; v.ir = 3'(ir); v.ic = 3'(ic); v.iv = iv; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_tile(input int fill, input int ir, input int ic, input int iv);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) tile[r][c] = fill;
    tile[ir][ic] = iv;
  endtask

  task automatic send(input logic m, input int nin, input bit toggle);
    for (int r = 0; r < nin; r++) begin
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
        in_d32[c*32 +: 32] = tile[r][c];
        in_d16[c*16 +: 16] = 16'(tile[r][c]);
      end
      mode     = (r == 0 || !toggle) ? m : ~m;
      in_valid = 1'b1;
      chk($sformatf("in_ready row%0d", r), longint'(in_ready), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_d32   = '0;
    in_d16   = '0;
  endtask

  // Called on the first negedge after the last acceptance: rows must appear
  // on consecutive cycles with no waiting.
  task automatic collect(input int nout, input logic [15:0][63:0] exp,
                         input int stall_k, input string tag);
    for (int k = 0; k < nout; k++) begin
      chk($sformatf("%s valid r%0d", tag, k),
          longint'({out_valid, out_valid_s, out_valid_w}), 7);
      chk($sformatf("%s last r%0d", tag, k), longint'(out_last), longint'(k == nout - 1));
      chk($sformatf("%s sat r%0d", tag, k), longint'(out_sat), 0);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s out[%0d][%0d]", tag, k, j),
            longint'($signed(out_data[j*64 +: 64])), longint'($signed(exp[k*4+j])));
        gs[k][j] = out_data_s[j*20 +: 20];
        gw[k][j] = out_data_w[j*20 +: 20];
      end
      sats[k] = out_sat_s;
      satw[k] = out_sat_w;
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk($sformatf("%s stall valid s%0d", tag, s), longint'(out_valid), 1);
          chk($sformatf("%s stall in_ready s%0d", tag, s), longint'(in_ready), 0);
          for (int j = 0; j < 4; j++)
            chk($sformatf("%s stall out[%0d][%0d] s%0d", tag, k, j, s),
                longint'($signed(out_data[j*64 +: 64])), longint'($signed(exp[k*4+j])));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk($sformatf("%s idle after tile", tag), longint'({out_valid, in_ready}), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_d32 = '0; in_d16 = '0;

    tbl[0] = mkv(0, 1, 0, 0, 1, mk(rw(25,0,50,5), rw(0,0,0,0), rw(50,0,100,10), rw(5,0,10,1)));
    tbl[1] = mkv(0, 0, 5, 5, 1, mk(rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,0), rw(0,0,0,1)));
    tbl[2] = mkv(0, 0, 4, 4, -1, mk(rw(-1,2,-4,8), rw(2,-4,8,-16), rw(-4,8,-16,32),
                                    rw(8,-16,32,-64)));
    tbl[3] = mkv(1, 1, 0, 0, 1, mk(rw(9,-3,0,0), rw(-3,1,0,0), rw(0,0,0,0), rw(0,0,0,0)));
    tbl[4] = mkv(0, 2, 0, 0, 7, mk(rw(55,0,100,10), rw(0,0,0,0), rw(100,0,200,20),
                                   rw(10,0,20,2)));
    tbl[5] = mkv(1, 0, 1, 2, 5, mk(rw(5,-5,0,0), rw(5,-5,0,0), rw(0,0,0,0), rw(0,0,0,0)));

    // Reset state
    @(negedge clk);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset out_data", longint'(|out_data), 0);
    chk("reset out_last", longint'(out_last), 0);
    chk("reset out_sat", longint'(out_sat), 0);
    chk("reset in_ready", longint'(in_ready), 0);
    rst = 1'b0;

    // Table-driven tiles
    for (int v = 0; v < 6; v++) begin
      set_tile(tbl[v].fill, int'(tbl[v].ir), int'(tbl[v].ic), tbl[v].iv);
      send(tbl[v].mode, tbl[v].mode ? 4 : 6, 1'b0);
      collect(tbl[v].mode ? 2 : 4, tbl[v].exp, -1, $sformatf("vec%0d", v));
    end

    // F(2,3) with mode toggled after row 0, then an F(4,3) tile
    set_tile(1, 0, 0, 1);
    send(1'b1, 4, 1'b1);
    collect(2, tbl[3].exp, -1, "toggle");
    send(1'b0, 6, 1'b0);
    collect(4, tbl[0].exp, -1, "b2b");

    // Backpressure on output row 1
    set_tile(0, 4, 4, -1);
    send(1'b0, 6, 1'b0);
    collect(4, tbl[2].exp, 1, "bp");

    // Narrow output: saturate vs wrap
    set_tile(32767, 0, 0, 32767);
    send(1'b0, 6, 1'b0);
    collect(4, mk(rw(819175,0,1638350,163835), rw(0,0,0,0),
                  rw(1638350,0,3276700,327670), rw(163835,0,327670,32767)), -1, "wide");
    chk("sat out[0][0]", longint'(gs[0][0]), 524287);
    chk("sat flag r0", longint'(sats[0]), 1);
    chk("sat out[1][0]", longint'(gs[1][0]), 0);
    chk("sat out[1][3]", longint'(gs[1][3]), 0);
    chk("sat flag r1", longint'(sats[1]), 0);
    chk("sat out[3][2]", longint'(gs[3][2]), 327670);
    chk("sat flag r3", longint'(sats[3]), 0);
    chk("wrap out[0][0]", longint'(gw[0][0]), -229401);
    chk("wrap out[0][2]", longint'(gw[0][2]), -458802);
    chk("wrap flag r0", longint'(satw[0]), 1);
    chk("wrap flag r1", longint'(satw[1]), 0);

    // Reset after 3 rows of a tile; out_data still holds the previous row
    set_tile(9, 0, 0, 9);
    send(1'b0, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", longint'(out_valid), 0);
    chk("midrst out_data", longint'(|out_data), 0);
    chk("midrst out_last", longint'(out_last), 0);
    chk("midrst out_sat", longint'(out_sat), 0);
    chk("midrst in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    set_tile(1, 0, 0, 1);
    send(1'b0, 6, 1'b0);
    collect(4, tbl[0].exp, -1, "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/winograd_post_transform_2d_stream.md
# winograd_post_transform_2d_stream

Streaming 2D Winograd output transform, Y = A^T·M·A, for one tile at a time. It accepts an element-wise-product tile M one row per beat and emits the spatial output tile one row per beat. It supports two runtime modes: F(4,3), with 6×6 in and 4×4 out, and F(2,3), with 4×4 in and 2×2 out. It sits between the Winograd element-wise multiply stage and the output accumulation/writeback, replacing per-row combinational 1D post-transforms with a parametrised, width-generic, saturating pipeline.

## Interface
- DATA_W, 32: signed width of each input element.
- OUT_W, 64: signed width of each output element.
- SATURATE, 1: when 1, results outside the OUT_W range clamp to signed min/max. When 0, they wrap (low OUT_W bits).

- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = F(4,3), 1 = F(2,3). Sampled only when row 0 of a tile is accepted.
- in_valid  in  1  input row valid.
- in_ready  out  1  input row accepted when in_valid && in_ready.
- in_data  in  6*DATA_W  six signed elements; element i at [i*DATA_W +: DATA_W]. In F(2,3) only elements 0..3 are used; 4..5 are ignored.
- out_valid  out  1  output row valid.
- out_ready  in  1  output row consumed when out_valid && out_ready.
- out_data  out  4*OUT_W  four signed elements; element j at [j*OUT_W +: OUT_W]. In F(2,3) elements 2..3 are 0.
- out_last  out  1  high with the final output row of a tile.
- out_sat  out  1  high with an output row in which at least one element saturated (SATURATE=1) or wrapped (SATURATE=0).

## Operation
- Coefficients:
  - F(4,3) A^T rows: [1 1 1 1 1 0], [0 1 -1 2 -2 0], [0 1 1 4 4 0], [0 1 -1 8 -8 1].
  - F(2,3) A^T rows: [1 1 1 0], [0 1 -1 -1].
  - N_IN = 6/4 and N_OUT = 4/2 for F(4,3)/F(2,3).
- FSM states LOAD and EMIT. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted row r is row-transformed combinationally: t[r][j] = Σ_i A^T[j][i]·in[i]. Multiplies are shifts/adds only.
  - The result is registered into buffer row r, and the row counter increments.
  - On row 0 acceptance the mode is latched. The latched mode governs the whole tile; mode changes mid-tile are ignored.
  - On acceptance of row N_IN-1, go to EMIT with the output counter at 0.
- EMIT:
  - in_ready=0.
  - out_data row k = Σ_i A^T[k][i]·t[i][j], computed from the buffer and registered.
  - Each out_valid&&out_ready handshake advances k.
  - On the handshake of row N_OUT-1 (out_last=1), return to LOAD with the row counter at 0.
- Widths:
  - The row pass is exact at DATA_W+5 bits (max coefficient magnitude sum 19).
  - The column pass is exact at DATA_W+10 bits.
  - If OUT_W ≥ DATA_W+10, results are sign-extended, never saturate, and out_sat is always 0.
  - Otherwise the SATURATE rule applies per element.
- No double buffering: the next tile's row 0 is accepted only after the last output handshake.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_sat=0, state=LOAD, counters=0, latched mode=0.
- in_ready is 0 while rst is high and 1 in LOAD from the first edge after deassertion.
- Latency: first output row is valid on the cycle after the edge that accepts the last input row.
- Throughput, with no stalls: N_IN + N_OUT cycles per tile, i.e. 10 for F(4,3) and 6 for F(2,3).
- A stalled output (out_ready=0) holds out_data/out_last/out_sat stable and out_valid high.
- in_valid gaps in LOAD insert idle cycles only; the buffer holds its contents.
- Asserting rst mid-tile discards the partial tile. After deassertion the next accepted row is row 0.

## Test plan
- F(4,3), all 36 inputs = 1, out_ready=1 → rows [25,0,50,5], [0,0,0,0], [50,0,100,10], [5,0,10,1]. out_last on row 3; out_valid on the 4 consecutive cycles following the 6th acceptance.
- F(4,3) impulse: in[5][5]=1, all others 0 → only out[3][3]=1. Repeat with in[4][4]=-1 → out[k][j] = -c_k·c_j with c = [1,-2,4,-8], e.g. out[3][3] = -64.
- F(2,3), all 16 inputs = 1 → rows [9,-3,0,0] and [-3,1,0,0]. Toggling mode after row 0 has no effect. A back-to-back F(4,3) tile follows correctly.
- DATA_W=16, OUT_W=20, SATURATE=1, all inputs 32767 → out[0][0] = 524287 with out_sat=1. Row 1 is 0 with out_sat=0. With SATURATE=0, out[0][0] = 819175 mod 2^20, interpreted as signed.
- Backpressure: out_ready=0 for 3 cycles on row 1 → out_data stable and in_ready=0 throughout. Row 1 is emitted once; no row is lost or duplicated.
- Reset mid-tile: assert rst after 3 rows accepted → outputs return to reset values immediately. A full new tile then produces correct results with no residue from the discarded rows.
